// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared FSM states, result-bit indices and the {a,b} sweep table for gate checkers.
package gate_chk_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, DRIVE = 3'd1, SETTLE = 3'd2, CHECK = 3'd3, DONE = 3'd4} state_t;
  localparam int B_AND  = 0;
  localparam int B_OR   = 1;
  localparam int B_NAND = 2;
  localparam int B_NOR  = 3;
  localparam int B_XOR  = 4;
  localparam int B_XNOR = 5;
  localparam int B_NA   = 6;
  localparam int B_NB   = 7;
  localparam logic [7:0] SWEEP = 8'b10_11_01_00;
  function automatic logic [1:0] sweep_ab(input logic [1:0] idx);
    return SWEEP[{idx, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/gate_vector_checker_ref_model.sv
// gate_ref_model: combinational expected result of the two-input gate bank for a given a,b.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [7:0] exp_o
);
  always_comb begin
    exp_o = '0;
    exp_o[B_AND]  = a_i & b_i;
    exp_o[B_OR]   = a_i | b_i;
    exp_o[B_NAND] = ~(a_i & b_i);
    exp_o[B_NOR]  = ~(a_i | b_i);
    exp_o[B_XOR]  = a_i ^ b_i;
    exp_o[B_XNOR] = ~(a_i ^ b_i);
    exp_o[B_NA]   = ~a_i;
    exp_o[B_NB]   = ~b_i;
  end
endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps a/b through the gate bank, settles, and checks o against the reference.
// Define CHK_HALT_ON_ERR_EN to stop the sweep at the first mismatching vector.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       o,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       fail_vec
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  state_t           state_q;
  logic [1:0]       idx_q;
  logic [CW-1:0]    cnt_q;
  logic             a_q, b_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       fail_q, exp_v, miss;
  logic             last;
  gate_ref_model u_ref (.a_i(a_q), .b_i(b_q), .exp_o(exp_v));
  assign miss  = o ^ exp_v;
  assign err_d = (miss != '0 && err_q != '1) ? err_q + 1'b1 : err_q;
`ifdef CHK_HALT_ON_ERR_EN
  assign last = (idx_q == 2'd3) || (miss != '0);
`else
  assign last = (idx_q == 2'd3);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= DRIVE;
          idx_q   <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          err_q   <= '0;
          fail_q  <= '0;
        end
        DRIVE: begin
          {a_q, b_q} <= sweep_ab(idx_q);
          cnt_q      <= CW'(SETTLE_CYC - 1);
          state_q    <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == '0) state_q <= CHECK;
          else cnt_q <= cnt_q - 1'b1;
        end
        CHECK: begin
          err_q <= err_d;
          if (miss != '0) fail_q <= miss;
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;
endmodule
